// File: rtl/pipeline_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_run_controller
// Description : Debug-unit run/step/halt sequencer for the MIPS pipeline enable,
//               with executed-cycle counter and zero-instruction end detection.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_controller #(
    parameter int END_ZEROS = 4,
    parameter int CNT_W     = 32
) (
    input  logic             pipeClk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic [31:0]      instruction_IFID,
    output logic             pipeEnable,
    output logic             programEnd,
    output logic             done,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycleCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0] c_CMD_RUN  = 2'b01;
    localparam logic [1:0] c_CMD_STEP = 2'b10;
    localparam logic [1:0] c_CMD_HALT = 2'b11;
    localparam logic [3:0] c_END      = 4'(END_ZEROS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_zero_cnt;
    logic [3:0]       w_zero_nxt;
    logic [3:0]       w_zero_inc;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_program_end;
    logic             w_pend_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_enabled;
    logic             w_accept;

    assign w_enabled  = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_zero_inc = (r_zero_cnt == c_END) ? c_END : r_zero_cnt + 4'd1;

    assign pipeEnable = w_enabled;
    assign cmd_ready  = (r_state != ST_STEP);
    assign state      = r_state;
    assign programEnd = r_program_end;
    assign done       = r_done;
    assign cycleCount = r_cycle_count;

    always_ff @(posedge pipeClk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // End detection overrides any command or STEP auto-return on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_zero_nxt  = r_zero_cnt;
        w_count_nxt = r_cycle_count;
        w_pend_nxt  = r_program_end;
        w_done_nxt  = 1'b0;

        if (w_enabled) begin
            w_count_nxt = r_cycle_count + CNT_W'(1);
            w_zero_nxt  = (instruction_IFID == 32'd0) ? w_zero_inc : 4'd0;
        end

        if (w_enabled && (w_zero_nxt == c_END)) begin
            w_state_nxt = ST_DONE;
            w_pend_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cmd)
                            c_CMD_RUN:  w_state_nxt = ST_RUN;
                            c_CMD_STEP: w_state_nxt = ST_STEP;
                            c_CMD_HALT: begin
                                w_count_nxt = '0;
                                w_zero_nxt  = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (w_accept && (cmd == c_CMD_HALT)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
                ST_DONE: begin
                    if (w_accept && (cmd == c_CMD_HALT)) begin
                        w_state_nxt = ST_IDLE;
                        w_pend_nxt  = 1'b0;
                        w_count_nxt = '0;
                        w_zero_nxt  = 4'd0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pipeClk or negedge reset) begin
        if (!reset) begin
            r_zero_cnt    <= 4'd0;
            r_cycle_count <= '0;
            r_program_end <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_zero_cnt    <= w_zero_nxt;
            r_cycle_count <= w_count_nxt;
            r_program_end <= w_pend_nxt;
            r_done        <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Sequences execution of the MIPS pipeline for the debug unit by driving the pipeline enable. Accepts run, single-step and halt commands over a valid/ready handshake. Counts executed cycles and raises an end-of-program flag once a configurable number of consecutive all-zero instructions has been fetched into IF/ID. Sits between the debug/UART command path and the pipeline stage registers.

## Interface
- END_ZEROS, 4, consecutive zero instructions in IF/ID that mark program end (1..15)
- CNT_W, 32, width of the executed-cycle counter

- pipeClk  in  1  free-running clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- cmd_valid  in  1  command present
- cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT
- cmd_ready  out  1  command accepted on an edge where cmd_valid && cmd_ready
- instruction_IFID  in  32  instruction currently in the IF/ID register
- pipeEnable  out  1  pipeline register enable
- programEnd  out  1  sticky end-of-program flag
- done  out  1  one-cycle pulse when a step completes or the program ends
- state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 DONE
- cycleCount  out  CNT_W  number of enabled cycles since the last clear

## Operation
- States:
  - IDLE: pipeline paused.
  - RUN: continuous execution.
  - STEP: exactly one enabled cycle.
  - DONE: program finished.
- pipeEnable = 1 iff state is RUN or STEP. It is decoded from the state register (Moore).
- cmd_ready = 1 in IDLE, RUN and DONE; 0 in STEP. Every accepted command is consumed, including ignored ones.
- IDLE transitions:
  - RUN → RUN.
  - STEP → STEP.
  - HALT → clear cycleCount and the zero counter, stay IDLE.
  - NOP → stay.
- RUN transitions:
  - HALT → IDLE, counters preserved (pause).
  - RUN/STEP/NOP → ignored.
- STEP always → IDLE next edge, with done=1 for one cycle.
- DONE transitions:
  - HALT → IDLE; clears programEnd, cycleCount and the zero counter.
  - All other commands ignored.
- Enabled cycle = an edge at which state is RUN or STEP. On each enabled cycle:
  - cycleCount += 1, wrapping modulo 2^CNT_W.
  - Zero counter +1 (saturating at END_ZEROS) if instruction_IFID == 0, else reset to 0. Zeros must be consecutive among enabled cycles.
  - instruction_IFID is ignored on non-enabled edges.
- End detection: on an enabled cycle where the zero counter reaches END_ZEROS:
  - state → DONE.
  - programEnd → 1.
  - done pulses once.
- Priority on a single edge: end detection > accepted command > STEP auto-return.
  - HALT arriving on the edge that reaches the threshold is consumed and ignored; the result is DONE.
  - A STEP that reaches the threshold goes to DONE, not IDLE, with a single done pulse.

## Timing
- Reset values: state IDLE, pipeEnable 0, programEnd 0, done 0, cycleCount 0, zero counter 0. cmd_ready is 1 (IDLE).
- Reset asserted mid-RUN drops pipeEnable immediately (asynchronous), not at the next edge.
- RUN accepted at edge N: pipeEnable = 1 from edge N; the first enabled edge is N+1.
- STEP accepted at edge N:
  - pipeEnable high for exactly the cycle N..N+1.
  - Edge N+1 is the single enabled edge, returns to IDLE, and raises done for the cycle N+1..N+2.
- HALT accepted in RUN at edge N: pipeEnable low from N. Edge N itself is still an enabled cycle (counted).
- Threshold reached at enabled edge N: pipeEnable falls, and programEnd/done rise, at N. The edge-N instruction is counted.
- done is registered, high exactly one cycle per event.
- cycleCount and programEnd are registered and update on the same edge as the state change.

## Test plan
- Reset, RUN; feed 7 nonzero instructions then zeros (END_ZEROS=4). Expected: DONE after the 4th zero, cycleCount=11, programEnd=1, one done pulse, pipeEnable=0.
- Zeros broken by a nonzero (0,0,0,X,0,0,0,0). Expected: no end after the first 3 zeros; end at the 8th enabled cycle, cycleCount=8.
- Three STEP commands, each with nonzero instructions. Expected: pipeEnable high exactly 1 cycle per step, cycleCount=3, three done pulses, cmd_ready low during each STEP cycle.
- RUN for 5 cycles, HALT, idle 10 cycles, RUN again. Expected: cycleCount continues from 5; zero inputs during idle are not counted.
- In DONE, issue RUN then HALT. Expected: RUN ignored (state stays 11). HALT returns to IDLE with programEnd=0 and cycleCount=0.
- Assert reset (0) mid-RUN, between edges. Expected: pipeEnable=0 and state=IDLE immediately; after release, RUN restarts the count from 0.
